// File: rtl/mc_pkg.sv
// Shared types for the missionaries-and-cannibals move engine: response codes,
// FSM state encodings, boat side constants and the bank safety rule.
package mc_pkg;

  typedef enum logic [2:0] {
    RSP_OK     = 3'd0,
    RSP_CAP    = 3'd1,
    RSP_AVAIL  = 3'd2,
    RSP_UNSAFE = 3'd3,
    RSP_EMPTY  = 3'd4
  } rsp_code_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic START = 1'b0;
  localparam logic FAR   = 1'b1;

  // A bank is unsafe when missionaries are present and outnumbered.
  function automatic logic bank_unsafe(input int m, input int c);
    return (m > 0) && (m < c);
  endfunction

endpackage

// File: rtl/mc_undo_stack.sv
// LIFO of committed moves kept in a circular buffer; when full, a push
// overwrites the oldest entry and the occupancy stays at DEPTH.
module mc_undo_stack #(
  parameter int DW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] top_data,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] last_ptr;
  logic [CW-1:0] count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? AW'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign last_ptr = ptr_dec(wr_ptr);
  assign top_data = mem[last_ptr];
  assign empty    = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= ptr_inc(wr_ptr);
      if (count != CW'(DEPTH)) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= last_ptr;
      count  <= count - 1'b1;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mc_move_engine.sv
// Host-driven missionaries-and-cannibals move engine: checks, commits and reports moves.
// Define MC_MOVE_ENGINE_UNDO_EN to add the mv_undo port and the undo history.
module mc_move_engine
  import mc_pkg::*;
#(
  parameter int N     = 3,
  parameter int CAP   = 2,
  parameter int DEPTH = 16,
  localparam int W    = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  // A request transfers on a rising edge with mv_valid && mv_ready; mv_ready is
  // registered and low during evaluation, so requests pace at one per two cycles.
  input  logic         mv_valid,
  output logic         mv_ready,
  input  logic [W-1:0] mv_m,
  input  logic [W-1:0] mv_c,
`ifdef MC_MOVE_ENGINE_UNDO_EN
  input  logic         mv_undo,
`endif
  output logic         rsp_valid,
  output logic [2:0]   rsp_code,
  output logic [W-1:0] m_left,
  output logic [W-1:0] c_left,
  output logic         boat_side,
  output logic [15:0]  move_count,
  output logic         finish,
  output logic [1:0]   dbg_state
);

`ifdef MC_MOVE_ENGINE_UNDO_EN
  localparam logic DONE_READY = 1'b1;
`else
  localparam logic DONE_READY = 1'b0;
`endif

  logic [1:0]   state;
  logic [W-1:0] req_m, req_c;
  logic         accept;
  logic         in_check;

  logic [W:0]   boat_sum;
  logic [W-1:0] bank_m, bank_c;
  logic [W-1:0] post_m, post_c;
  logic         cap_bad, avail_bad, unsafe_bad;

  rsp_code_e    code;
  logic [W-1:0] nx_m, nx_c;
  logic         nx_side;
  logic [15:0]  nx_count;
  logic         nx_finish;
  logic         commit;

  assign accept    = mv_valid && mv_ready && !restart;
  assign in_check  = (state == ST_CHECK) && !restart;
  assign dbg_state = state;

  assign boat_sum = {1'b0, req_m} + {1'b0, req_c};
  assign bank_m   = (boat_side == FAR) ? W'(N) - m_left : m_left;
  assign bank_c   = (boat_side == FAR) ? W'(N) - c_left : c_left;
  // Start-bank counts after the crossing; meaningful only once AVAIL has passed.
  assign post_m   = (boat_side == FAR) ? m_left + req_m : m_left - req_m;
  assign post_c   = (boat_side == FAR) ? c_left + req_c : c_left - req_c;

  assign cap_bad    = (boat_sum == '0) || (int'(boat_sum) > CAP);
  assign avail_bad  = (req_m > bank_m) || (req_c > bank_c);
  assign unsafe_bad = bank_unsafe(int'(post_m), int'(post_c)) ||
                      bank_unsafe(N - int'(post_m), N - int'(post_c));

`ifdef MC_MOVE_ENGINE_UNDO_EN
  logic           req_undo;
  logic           undo_ok;
  logic [2*W-1:0] hist_top;
  logic           hist_empty;
  logic [W-1:0]   undo_m, undo_c;

  // Reversal direction follows the current boat side: the boat sits on the bank it last moved to.
  assign undo_m = (boat_side == FAR) ? m_left + hist_top[2*W-1:W] : m_left - hist_top[2*W-1:W];
  assign undo_c = (boat_side == FAR) ? c_left + hist_top[W-1:0]   : c_left - hist_top[W-1:0];

  mc_undo_stack #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart),
    .push      (in_check && commit),
    .pop       (in_check && undo_ok),
    .push_data ({req_m, req_c}),
    .top_data  (hist_top),
    .empty     (hist_empty)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{commit, DEPTH};
`endif

  always_comb begin
    code     = RSP_OK;
    nx_m     = m_left;
    nx_c     = c_left;
    nx_side  = boat_side;
    nx_count = move_count;
    commit   = 1'b0;
`ifdef MC_MOVE_ENGINE_UNDO_EN
    undo_ok  = 1'b0;
    if (req_undo) begin
      if (hist_empty) begin
        code = RSP_EMPTY;
      end else begin
        undo_ok  = 1'b1;
        nx_m     = undo_m;
        nx_c     = undo_c;
        nx_side  = ~boat_side;
        nx_count = (move_count == 16'd0) ? 16'd0 : move_count - 16'd1;
      end
    end else
`endif
    if (finish) begin
      code = RSP_AVAIL;
    end else if (cap_bad) begin
      code = RSP_CAP;
    end else if (avail_bad) begin
      code = RSP_AVAIL;
    end else if (unsafe_bad) begin
      code = RSP_UNSAFE;
    end else begin
      commit   = 1'b1;
      nx_m     = post_m;
      nx_c     = post_c;
      nx_side  = ~boat_side;
      nx_count = (move_count == 16'hFFFF) ? move_count : move_count + 16'd1;
    end
  end

  assign nx_finish = (nx_m == '0) && (nx_c == '0) && (nx_side == FAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mv_ready   <= 1'b1;
      req_m      <= '0;
      req_c      <= '0;
      rsp_valid  <= 1'b0;
      rsp_code   <= RSP_OK;
      m_left     <= W'(N);
      c_left     <= W'(N);
      boat_side  <= START;
      move_count <= 16'd0;
      finish     <= 1'b0;
`ifdef MC_MOVE_ENGINE_UNDO_EN
      req_undo   <= 1'b0;
`endif
    end else if (restart) begin
      state      <= ST_IDLE;
      mv_ready   <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_code   <= RSP_OK;
      m_left     <= W'(N);
      c_left     <= W'(N);
      boat_side  <= START;
      move_count <= 16'd0;
      finish     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == ST_CHECK) begin
        rsp_valid  <= 1'b1;
        rsp_code   <= code;
        m_left     <= nx_m;
        c_left     <= nx_c;
        boat_side  <= nx_side;
        move_count <= nx_count;
        finish     <= nx_finish;
        state      <= nx_finish ? ST_DONE : ST_IDLE;
        mv_ready   <= nx_finish ? DONE_READY : 1'b1;
      end else if (state != ST_IDLE && state != ST_DONE) begin
        state    <= ST_IDLE;
        mv_ready <= 1'b1;
      end else if (accept) begin
        req_m    <= mv_m;
        req_c    <= mv_c;
`ifdef MC_MOVE_ENGINE_UNDO_EN
        req_undo <= mv_undo;
`endif
        state    <= ST_CHECK;
        mv_ready <= 1'b0;
      end
    end
  end

endmodule
